rom_loader: RTL and testbench

ROM_LOADER -- requirements
Module: rom_loader

---
 rtl/rom_loader_pkg.sv | 24 ++
 rtl/rom_loader.sv | 187 ++++++++++++++++++
 tb/tb_rom_loader.sv | 380 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rom_loader_pkg.sv
// rom_loader_pkg
//   Shared types and constants for the ROM download loader.
//   - state_t      : loader FSM states
//   - ADDR_W       : byte/word address width (27)
//   - SIZE_W       : byte-count width (28), one bit wider so a full 2^27 image fits
//   - PAD_BYTE_DEF : default fill byte for an unpaired half-word
package rom_loader_pkg;

    localparam int ADDR_W = 27;
    localparam int SIZE_W = 28;

    localparam logic [7:0] PAD_BYTE_DEF = 8'hFF;

    typedef enum logic [2:0] {
        SYNC,
        IDLE,
        FILL,
        ISSUE,
        WAIT_ACK,
        FLUSH,
        DONE
    } state_t;

endpackage

// File: rtl/rom_loader.sv
// rom_loader
//   Packs a byte-wide ioctl download stream into 16-bit words and hands each
//   word to a DDR write stage over a toggle req/ack handshake.
//
//   Optional feature: define ROM_LOADER_CHECKSUM_EN to add the checksum port
//   (16-bit modulo sum of all accepted bytes, valid when load_done=1).
//
//   Ports
//     DDRAM_CLK      in   clock, rising edge
//     reset          in   asynchronous, active-low
//     ioctl_download in   download session active
//     ioctl_index    in   [7:0]  target selector, must equal ROM_INDEX
//     ioctl_wr       in   byte strobe
//     ioctl_addr     in   [26:0] byte address
//     ioctl_dout     in   [7:0]  byte data
//     ioctl_wait     out  host backpressure
//     wraddr         out  [26:0] word address for the DDR write port
//     din            out  [15:0] packed word, even byte low / odd byte high
//     write_rom_req  out  toggle request
//     write_rom_ack  in   toggle acknowledge
//     rom_size       out  [27:0] highest accepted byte address + 1
//     load_done      out  session ended and every word acknowledged
//     checksum       out  [15:0] (only with ROM_LOADER_CHECKSUM_EN)
module rom_loader
    import rom_loader_pkg::*;
#(
    parameter logic [7:0]        ROM_INDEX  = 8'd0,
    parameter logic [ADDR_W-1:0] BASE_WADDR = 27'd0,
    parameter logic [7:0]        PAD_BYTE   = PAD_BYTE_DEF
) (
    input  logic              DDRAM_CLK,
    input  logic              reset,
    input  logic              ioctl_download,
    input  logic [7:0]        ioctl_index,
    input  logic              ioctl_wr,
    input  logic [ADDR_W-1:0] ioctl_addr,
    input  logic [7:0]        ioctl_dout,
    output logic              ioctl_wait,
    output logic [ADDR_W-1:0] wraddr,
    output logic [15:0]       din,
    output logic              write_rom_req,
    input  logic              write_rom_ack,
    output logic [SIZE_W-1:0] rom_size,
    output logic              load_done
`ifdef ROM_LOADER_CHECKSUM_EN
    ,
    output logic [15:0]       checksum
`endif
);

    state_t            state;
    logic              sess, sess_q, sess_fall, sess_rise;
    logic              live;        // current session has not ended yet
    logic              start_pend;  // rising edge seen while busy with the previous session
    logic              half;        // din[7:0]/wraddr hold an unpaired even byte
    logic              hold_vld;
    logic [7:0]        hold_data;
    logic [ADDR_W-1:0] hold_addr;
    logic              accept, start, ack_ok, idle_like;
    logic [ADDR_W-1:0] byte_waddr;
    logic [SIZE_W-1:0] byte_end;

    assign sess       = ioctl_download && (ioctl_index == ROM_INDEX);
    assign sess_rise  = sess && !sess_q;
    assign sess_fall  = sess_q && !sess;
    assign accept     = sess && ioctl_wr;
    assign start      = sess_rise || start_pend;
    assign idle_like  = (state == IDLE) || (state == DONE);
    assign ack_ok     = (write_rom_ack == write_rom_req);
    // Word address wraps modulo 2^27 with the base offset.
    assign byte_waddr = {1'b0, ioctl_addr[ADDR_W-1:1]} + BASE_WADDR;
    // 28-bit so addr 2^27-1 yields 2^27 without wrapping.
    assign byte_end   = {1'b0, ioctl_addr} + SIZE_W'(1);

    // Decoded from registers only; SYNC is the reset state, so this is 1 in reset.
    assign ioctl_wait = (state == SYNC) || (state == ISSUE) ||
                        (state == WAIT_ACK) || hold_vld;

    always_ff @(posedge DDRAM_CLK or negedge reset) begin
        if (!reset) begin
            state         <= SYNC;
            write_rom_req <= 1'b0;
            load_done     <= 1'b0;
            rom_size      <= '0;
            din           <= '0;
            wraddr        <= '0;
            half          <= 1'b0;
            hold_vld      <= 1'b0;
            hold_data     <= '0;
            hold_addr     <= '0;
            sess_q        <= 1'b0;
            live          <= 1'b0;
            start_pend    <= 1'b0;
`ifdef ROM_LOADER_CHECKSUM_EN
            checksum      <= '0;
`endif
        end else begin
            sess_q <= sess;
            if (sess_fall) live <= 1'b0;
            if (sess_rise && !idle_like) start_pend <= 1'b1;

            case (state)
                // Align req to whatever ack the write stage holds so nothing looks pending.
                SYNC: begin
                    write_rom_req <= write_rom_ack;
                    state         <= IDLE;
                end

                IDLE, DONE: begin
                    if (start) begin
                        rom_size   <= '0;
                        load_done  <= 1'b0;
                        half       <= 1'b0;
                        hold_vld   <= 1'b0;
                        live       <= 1'b1;
                        start_pend <= 1'b0;
`ifdef ROM_LOADER_CHECKSUM_EN
                        checksum   <= '0;
`endif
                        state      <= FILL;
                    end
                end

                FILL: begin
                    if (accept) begin
                        if (byte_end > rom_size) rom_size <= byte_end;
`ifdef ROM_LOADER_CHECKSUM_EN
                        checksum <= checksum + {8'd0, ioctl_dout};
`endif
                        if (!ioctl_addr[0]) begin
                            if (half && (byte_waddr != wraddr)) begin
                                // Flush the unpaired byte first; park the new one.
                                din[15:8] <= PAD_BYTE;
                                hold_vld  <= 1'b1;
                                hold_data <= ioctl_dout;
                                hold_addr <= byte_waddr;
                                state     <= ISSUE;
                            end else begin
                                din[7:0]  <= ioctl_dout;
                                wraddr    <= byte_waddr;
                                half      <= 1'b1;
                            end
                        end else begin
                            din[15:8] <= ioctl_dout;
                            if (!half || (byte_waddr != wraddr)) din[7:0] <= PAD_BYTE;
                            wraddr    <= byte_waddr;
                            state     <= ISSUE;
                        end
                    end else if (!sess || !live) begin
                        state <= FLUSH;
                    end
                end

                ISSUE: begin
                    write_rom_req <= ~write_rom_req;
                    half          <= 1'b0;
                    state         <= WAIT_ACK;
                end

                WAIT_ACK: begin
                    if (ack_ok) begin
                        if (hold_vld) begin
                            din[7:0] <= hold_data;
                            wraddr   <= hold_addr;
                            half     <= 1'b1;
                            hold_vld <= 1'b0;
                        end
                        state <= (sess && live) ? FILL : FLUSH;
                    end
                end

                FLUSH: begin
                    if (half) begin
                        din[15:8] <= PAD_BYTE;
                        state     <= ISSUE;
                    end else begin
                        load_done <= 1'b1;
                        state     <= DONE;
                    end
                end

                default: state <= SYNC;
            endcase
        end
    end

endmodule

// File: tb/tb_rom_loader.sv
// tb_rom_loader
//   Scoreboard bench for rom_loader: expected words are queued as bytes are
//   driven and popped when write_rom_req toggles. A negedge monitor also acts
//   as the DDR write stage (ack with programmable delay).
module tb_rom_loader;

    logic        DDRAM_CLK = 1'b0;
    logic        reset = 1'b0;
    logic        ioctl_download = 1'b0;
    logic [7:0]  ioctl_index = 8'd0;
    logic        ioctl_wr = 1'b0;
    logic [26:0] ioctl_addr = '0;
    logic [7:0]  ioctl_dout = '0;
    logic        ioctl_wait;
    logic [26:0] wraddr;
    logic [15:0] din;
    logic        write_rom_req;
    logic        write_rom_ack = 1'b0;
    logic [27:0] rom_size;
    logic        load_done;
`ifdef ROM_LOADER_CHECKSUM_EN
    logic [15:0] checksum;
`endif

    rom_loader dut (
        .DDRAM_CLK     (DDRAM_CLK),
        .reset         (reset),
        .ioctl_download(ioctl_download),
        .ioctl_index   (ioctl_index),
        .ioctl_wr      (ioctl_wr),
        .ioctl_addr    (ioctl_addr),
        .ioctl_dout    (ioctl_dout),
        .ioctl_wait    (ioctl_wait),
        .wraddr        (wraddr),
        .din           (din),
        .write_rom_req (write_rom_req),
        .write_rom_ack (write_rom_ack),
        .rom_size      (rom_size),
        .load_done     (load_done)
`ifdef ROM_LOADER_CHECKSUM_EN
        ,
        .checksum      (checksum)
`endif
    );

    always #5 DDRAM_CLK = ~DDRAM_CLK;

    typedef struct packed {
        logic [26:0] a;
        logic [15:0] d;
    } word_t;

    word_t       exp_q[$];
    int          checks = 0;
    int          errors = 0;
    bit          resp_en = 1'b0;
    int          ack_delay = 0;
    bit          ack_preset_en = 1'b0;
    logic        ack_preset = 1'b0;
    int          req_count = 0;

    // Write-stage model plus request checker.
    task automatic monitor();
        logic        prev_req = 1'b0, prev_ack = 1'b0;
        logic [26:0] cap_a = '0;
        logic [15:0] cap_d = '0;
        int          ack_cnt = 0;
        int          rel_cnt = 0;
        word_t       w;
        forever begin
            @(negedge DDRAM_CLK);
            if (!reset) begin
                ack_cnt = 0;
                rel_cnt = 0;
                if (ack_preset_en) write_rom_ack = ack_preset;
            end else if (rel_cnt < 2) begin
                rel_cnt++;
            end else begin
                if (write_rom_req != prev_req && write_rom_req != write_rom_ack) begin
                    req_count++;
                    checks++;
                    if (prev_req != prev_ack) begin
                        errors++;
                        $display("FAIL outstanding: new request while req=%b ack=%b pending", prev_req, prev_ack);
                    end
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL spurious_req: wraddr=%h din=%h, no word expected", wraddr, din);
                    end else begin
                        w = exp_q.pop_front();
                        if (wraddr !== w.a || din !== w.d) begin
                            errors++;
                            $display("FAIL word: got wraddr=%h din=%h, expected wraddr=%h din=%h", wraddr, din, w.a, w.d);
                        end
                    end
                    cap_a = wraddr;
                    cap_d = din;
                end else if (write_rom_req != write_rom_ack) begin
                    checks++;
                    if (wraddr !== cap_a || din !== cap_d) begin
                        errors++;
                        $display("FAIL stable: wraddr=%h din=%h changed from %h %h while pending", wraddr, din, cap_a, cap_d);
                    end
                end
                if (resp_en && write_rom_req != write_rom_ack) begin
                    if (ack_cnt >= ack_delay) begin
                        write_rom_ack = write_rom_req;
                        ack_cnt = 0;
                    end else begin
                        ack_cnt++;
                    end
                end
            end
            prev_req = write_rom_req;
            prev_ack = write_rom_ack;
        end
    endtask

    task automatic send_byte(input logic [26:0] a, input logic [7:0] d);
        int n = 0;
        while (ioctl_wait !== 1'b0 && n < 300) begin
            @(negedge DDRAM_CLK);
            n++;
        end
        checks++;
        if (ioctl_wait !== 1'b0) begin
            errors++;
            $display("FAIL wait_timeout: ioctl_wait=%b before byte @%0d, required 0", ioctl_wait, a);
        end
        ioctl_addr = a;
        ioctl_dout = d;
        ioctl_wr   = 1'b1;
        @(negedge DDRAM_CLK);
        ioctl_wr   = 1'b0;
    endtask

    task automatic start_session();
        ioctl_index    = 8'd0;
        ioctl_download = 1'b1;
        @(negedge DDRAM_CLK);
    endtask

    task automatic wait_done();
        int n = 0;
        while (load_done !== 1'b1 && n < 300) begin
            @(negedge DDRAM_CLK);
            n++;
        end
        checks++;
        if (load_done !== 1'b1) begin
            errors++;
            $display("FAIL load_done: got %b, required 1", load_done);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        checks++;
        if (write_rom_req !== 1'b0 || ioctl_wait !== 1'b1 || load_done !== 1'b0 ||
            rom_size !== 28'd0 || din !== 16'd0 || wraddr !== 27'd0) begin
            errors++;
            $display("FAIL %s: req=%b wait=%b done=%b size=%h din=%h wraddr=%h, required 0 1 0 0 0 0",
                     tag, write_rom_req, ioctl_wait, load_done, rom_size, din, wraddr);
        end
    endtask

    task automatic test_reset();
        @(negedge DDRAM_CLK);
        check_reset_vals("reset_state");
        reset = 1'b1;
        repeat (2) @(negedge DDRAM_CLK);
        checks++;
        if (ioctl_wait !== 1'b0 || write_rom_req !== write_rom_ack) begin
            errors++;
            $display("FAIL post_sync: wait=%b req=%b ack=%b, required wait 0 and req==ack", ioctl_wait, write_rom_req, write_rom_ack);
        end
    endtask

    task automatic test_basic();
        logic r0;
        resp_en   = 1'b1;
        ack_delay = 0;
        start_session();
        exp_q.push_back({27'd0, 16'h2211});
        send_byte(27'd0, 8'h11);
        r0 = write_rom_req;
        send_byte(27'd1, 8'h22);
        checks++;
        if (write_rom_req !== r0) begin
            errors++;
            $display("FAIL latency_early: req=%b, required %b", write_rom_req, r0);
        end
        @(negedge DDRAM_CLK);
        checks++;
        if (write_rom_req !== ~r0) begin
            errors++;
            $display("FAIL latency: req=%b, required %b", write_rom_req, ~r0);
        end
        ioctl_download = 1'b0;
        wait_done();
        checks++;
        if (rom_size !== 28'd2) begin
            errors++;
            $display("FAIL basic_size: got %0d, required 2", rom_size);
        end
    endtask

    task automatic test_flush();
        ack_delay = 3;
        start_session();
        exp_q.push_back({27'd2, 16'hFFAA});
        send_byte(27'd4, 8'hAA);
        ioctl_index = 8'd1;            // session ends through index mismatch
        @(negedge DDRAM_CLK);
        checks++;
        if (load_done !== 1'b0) begin
            errors++;
            $display("FAIL flush_early_done: got %b, required 0", load_done);
        end
        wait_done();
        checks++;
        if (rom_size !== 28'd5) begin
            errors++;
            $display("FAIL flush_size: got %0d, required 5", rom_size);
        end
        ioctl_download = 1'b0;
        ioctl_index    = 8'd0;
        @(negedge DDRAM_CLK);
    endtask

    task automatic test_backpressure();
        logic r;
        ack_delay = 10;
        start_session();
        exp_q.push_back({27'd0, 16'h2211});
        exp_q.push_back({27'd1, 16'h4433});
        send_byte(27'd0, 8'h11);
        send_byte(27'd1, 8'h22);
        @(negedge DDRAM_CLK);
        r = write_rom_req;
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (ioctl_wait !== 1'b1 || write_rom_req !== r) begin
                errors++;
                $display("FAIL backpressure[%0d]: wait=%b req=%b, required wait 1 req %b", i, ioctl_wait, write_rom_req, r);
            end
            @(negedge DDRAM_CLK);
        end
        ack_delay = 0;
        send_byte(27'd2, 8'h33);
        send_byte(27'd3, 8'h44);
        ioctl_download = 1'b0;
        wait_done();
        checks++;
        if (rom_size !== 28'd4) begin
            errors++;
            $display("FAIL bp_size: got %0d, required 4", rom_size);
        end
    endtask

    task automatic test_jump();
        ack_delay = 0;
        start_session();
        exp_q.push_back({27'd0, 16'hFF01});
        exp_q.push_back({27'd3, 16'h0302});
        send_byte(27'd0, 8'h01);
        send_byte(27'd6, 8'h02);
        checks++;
        if (ioctl_wait !== 1'b1) begin
            errors++;
            $display("FAIL jump_hold_wait: got %b, required 1", ioctl_wait);
        end
        send_byte(27'd7, 8'h03);
        checks++;
        if (wraddr !== 27'd3) begin
            errors++;
            $display("FAIL jump_wraddr: got %0d, required 3", wraddr);
        end
        ioctl_download = 1'b0;
        wait_done();
        checks++;
        if (rom_size !== 28'd8) begin
            errors++;
            $display("FAIL jump_size: got %0d, required 8", rom_size);
        end
    endtask

    task automatic test_ack_at_reset();
        int c0;
        resp_en       = 1'b0;
        ack_preset    = 1'b1;
        ack_preset_en = 1'b1;
        reset         = 1'b0;
        repeat (2) @(negedge DDRAM_CLK);
        reset         = 1'b1;
        ack_preset_en = 1'b0;
        c0 = req_count;
        repeat (3) @(negedge DDRAM_CLK);
        checks++;
        if (write_rom_req !== 1'b1 || ioctl_wait !== 1'b0 || req_count != c0) begin
            errors++;
            $display("FAIL ack_at_reset: req=%b wait=%b reqs=%0d, required req 1 wait 0 reqs %0d",
                     write_rom_req, ioctl_wait, req_count, c0);
        end
        resp_en   = 1'b1;
        ack_delay = 0;
        start_session();
        exp_q.push_back({27'd0, 16'h6655});
        send_byte(27'd0, 8'h55);
        send_byte(27'd1, 8'h66);
        ioctl_download = 1'b0;
        wait_done();
        checks++;
        if (write_rom_req !== 1'b0) begin
            errors++;
            $display("FAIL ack_at_reset_toggle: req=%b, required 0", write_rom_req);
        end
    endtask

    task automatic test_reset_mid();
        ack_delay = 1000;
        start_session();
        exp_q.push_back({27'd0, 16'h3412});
        send_byte(27'd0, 8'h12);
        send_byte(27'd1, 8'h34);
        repeat (3) @(negedge DDRAM_CLK);
        reset          = 1'b0;
        ioctl_download = 1'b0;
        @(negedge DDRAM_CLK);
        check_reset_vals("reset_mid");
        ack_delay = 0;
        reset     = 1'b1;
        repeat (3) @(negedge DDRAM_CLK);
        checks++;
        if (write_rom_req !== write_rom_ack || ioctl_wait !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_sync: req=%b ack=%b wait=%b, required req==ack wait 0", write_rom_req, write_rom_ack, ioctl_wait);
        end
        start_session();
        exp_q.push_back({27'd0, 16'h02FF});
        send_byte(27'd0, 8'hFF);
        send_byte(27'd1, 8'h02);
        ioctl_download = 1'b0;
        wait_done();
        checks++;
        if (rom_size !== 28'd2) begin
            errors++;
            $display("FAIL reset_mid_size: got %0d, required 2", rom_size);
        end
`ifdef ROM_LOADER_CHECKSUM_EN
        checks++;
        if (checksum !== 16'h0101) begin
            errors++;
            $display("FAIL checksum: got %h, required 0101", checksum);
        end
`endif
    endtask

    initial begin
        fork
            monitor();
        join_none
        test_reset();
        test_basic();
        test_flush();
        test_backpressure();
        test_jump();
        test_ack_at_reset();
        test_reset_mid();
        repeat (2) @(negedge DDRAM_CLK);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d words never issued, required 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
